// File: rtl/alu_pkg.sv
// Shared types for the ALU pipeline: opcodes and control-FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        MULT = 3'd2,
        AND  = 3'd3,
        OR   = 3'd4,
        XOR  = 3'd5
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation request / result handshake bundle between a producer and the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    opcode_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, overflow
    );

endinterface

// File: rtl/alu_mult_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per clock, WIDTH clocks per product.
module alu_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   w_acc_next;

    // product already includes the final partial product while done is high,
    // so the consumer can capture it on the same edge that ends the run.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign done       = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign product    = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_acc    <= '0;
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (done) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle add/sub/logic ops, multi-cycle multiply via alu_mult_seq.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_pipe_if.slave   bus
);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_result;
    logic                 r_overflow;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_mult_done;
    logic [2*WIDTH-1:0]   w_product;
    logic [WIDTH:0]       w_alu;

    // Returns {flag, result}; MULT and undefined opcodes fall to zero here.
    function automatic logic [WIDTH:0] alu_eval(
        input opcode_t          op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] t;
        case (op)
            ADD:     t = {1'b0, a} + {1'b0, b};
            SUB:     t = {1'b0, a} - {1'b0, b};
            AND:     t = {1'b0, a & b};
            OR:      t = {1'b0, a | b};
            XOR:     t = {1'b0, a ^ b};
            default: t = '0;
        endcase
        return t;
    endfunction

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_start  = w_accept && (bus.op == MULT);
    assign w_alu    = alu_eval(bus.op, bus.a, bus.b);

    alu_mult_seq #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (w_mult_done),
        .product (w_product)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = (bus.op == MULT) ? MUL : OUT;
            MUL:     if (w_mult_done) w_state_next = OUT;
            OUT:     if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && (bus.op != MULT)) begin
                r_result   <= w_alu[WIDTH-1:0];
                r_overflow <= w_alu[WIDTH];
            end else if ((r_state == MUL) && w_mult_done) begin
                r_result   <= w_product[WIDTH-1:0];
                r_overflow <= |w_product[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == OUT);
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed + randomized bench for alu_pipe with a queue-based expected-result scoreboard.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_pipe_if #(.WIDTH(W)) bus();

    alu_pipe #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model; lat = cycles from the cycle after acceptance until out_valid.
    function automatic exp_t model(input opcode_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t          e;
        logic [2*W-1:0] s;
        logic [2*W-1:0] p;
        e.lat = 0;
        e.res = '0;
        e.ovf = 1'b0;
        case (op)
            ADD: begin
                s = {{W{1'b0}}, a} + {{W{1'b0}}, b};
                e.res = s[W-1:0];
                e.ovf = s[W];
            end
            SUB: begin
                e.res = a - b;
                e.ovf = (b > a);
            end
            MULT: begin
                p = (2*W)'(a) * (2*W)'(b);
                e.res = p[W-1:0];
                e.ovf = (p[2*W-1:W] != '0);
                e.lat = W;
            end
            AND: e.res = a & b;
            OR:  e.res = a | b;
            XOR: e.res = a ^ b;
            default: begin
                e.res = '0;
                e.ovf = 1'b0;
            end
        endcase
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input opcode_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        step();
        sb.push_back(model(op, a, b));
        // Scramble operands after capture; they must not affect the pending op.
        bus.in_valid = 1'b0;
        bus.op       = opcode_t'($urandom_range(0, 7));
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic collect(input string tag, input int hold, input bit poke);
        exp_t e;
        int   lat = 0;
        bus.out_ready = (hold == 0);
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
        chk({tag, "_res"}, 64'(bus.result), 64'(e.res));
        chk({tag, "_ovf"}, 64'(bus.overflow), 64'(e.ovf));
        if (poke) begin
            bus.in_valid = 1'b1;
            bus.op       = ADD;
            bus.a        = 32'h1;
            bus.b        = 32'h1;
        end
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_rdy"}, 64'(bus.in_ready), 64'd0);
            chk({tag, "_hold_res"}, 64'(bus.result), 64'(e.res));
        end
        bus.out_ready = 1'b1;
        step();
        chk({tag, "_idle_vld"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bit saw;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = ADD;
        bus.a         = '0;
        bus.b         = '0;
        rst           = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);

        issue(ADD, 32'hFFFF_FFFF, 32'h1);            collect("add_wrap", 0, 1'b0);
        issue(SUB, 32'd3, 32'd5);                    collect("sub_borrow", 0, 1'b0);
        issue(SUB, 32'd5, 32'd3);                    collect("sub_plain", 0, 1'b0);
        issue(MULT, 32'h0001_0000, 32'h0001_0000);   collect("mul_ovf", 0, 1'b0);
        issue(MULT, 32'd7, 32'd6);                   collect("mul_small", 0, 1'b0);
        issue(XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);    collect("xor_hold", 5, 1'b1);
        issue(AND, 32'hDEAD_BEEF, 32'h0F0F_FFFF);    collect("and", 1, 1'b0);
        issue(OR, 32'h1234_0000, 32'h0000_5678);     collect("or", 0, 1'b0);
        issue(opcode_t'(3'd7), 32'd1, 32'd1);        collect("undef7", 0, 1'b0);
        issue(opcode_t'(3'd6), 32'hFFFF_FFFF, 32'd9); collect("undef6", 0, 1'b0);
        issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   collect("mul_max", 2, 1'b0);

        // Reset ten cycles into a multiply must discard the pending product.
        issue(MULT, 32'd123, 32'd456);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_front());
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_result", 64'(bus.result), 64'd0);
        chk("abort_overflow", 64'(bus.overflow), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        saw = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) begin
            step();
            if (bus.out_valid === 1'b1) saw = 1'b1;
        end
        bus.out_ready = 1'b0;
        chk("abort_no_stale", 64'(saw), 64'd0);

        for (int i = 0; i < 8; i++) begin
            issue(opcode_t'($urandom_range(0, 7)), $urandom, $urandom);
            collect("rand", $urandom_range(0, 2), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width in bits; legal range 4..64.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port in_valid, input, 1, SHALL mark a valid operation on op/a/b.
REQ-005 Port in_ready, output, 1, SHALL mark that the block accepts an operation this cycle.
REQ-006 Port op, input, opcode_t, SHALL select the operation.
REQ-007 Ports a and b, input, WIDTH each, SHALL be unsigned operands.
REQ-008 Port out_valid, output, 1, SHALL mark that result and overflow are valid.
REQ-009 Port out_ready, input, 1, SHALL mark that the consumer takes the result this cycle.
REQ-010 Port result, output, WIDTH, SHALL carry the operation result.
REQ-011 Port overflow, output, 1, SHALL carry the carry, borrow or product-overflow flag.

Function
REQ-012 Input handshake SHALL occur on a rising edge where in_valid and in_ready are both 1; op, a and b are captured only then.
REQ-013 Output handshake SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-014 FSM states SHALL be IDLE, MUL and OUT; in_ready = 1 only in IDLE; out_valid = 1 only in OUT.
REQ-015 IDLE with no input handshake SHALL stay in IDLE.
REQ-016 IDLE with input handshake and op other than MULT SHALL register the result and go to OUT, so out_valid is high in the next cycle (latency 1).
REQ-017 IDLE with input handshake and op = MULT SHALL go to MUL and load sub-module alu_mult_seq with a and b.
REQ-018 MUL SHALL run WIDTH shift-add iterations, one per cycle, counted by an iteration counter that wraps to 0 at exit; after the WIDTH-th edge in MUL it SHALL go to OUT, so out_valid rises WIDTH cycles after acceptance.
REQ-019 OUT SHALL hold result and overflow stable while out_ready = 0, with no timeout.
REQ-020 OUT with output handshake SHALL return to IDLE; a new input is not accepted on that same edge.
REQ-021 ADD: result = (a + b) mod 2^WIDTH; overflow = carry out of bit WIDTH-1.
REQ-022 SUB: result = (a - b) mod 2^WIDTH; overflow = 1 iff b > a (borrow).
REQ-023 MULT: result = low WIDTH bits of the 2*WIDTH-bit product; overflow = 1 iff the high WIDTH bits are nonzero.
REQ-024 AND, OR, XOR: bitwise result; overflow = 0.
REQ-025 Any undefined opcode value SHALL give result = 0 and overflow = 0, with latency 1.
REQ-026 Changes on op/a/b while the FSM is in MUL or OUT SHALL have no effect.

Reset
REQ-027 While rst = 1 at a rising edge, the FSM SHALL go to IDLE and the iteration counter and all multiplier registers SHALL clear to 0.
REQ-028 After reset: result = 0, overflow = 0, out_valid = 0, in_ready = 1 in the cycle following reset.
REQ-029 rst during MUL or OUT SHALL abort the operation; the pending result is discarded and never presented.
REQ-030 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-031 Package alu_pkg SHALL hold opcode_t (3-bit enum: ADD=0, SUB=1, MULT=2, AND=3, OR=4, XOR=5) and state_t (IDLE, MUL, OUT).
REQ-032 Sub-module alu_mult_seq SHALL implement the iterative unsigned shift-add multiplier.
REQ-033 alu_mult_seq SHALL be parametrised by WIDTH, with ports clk, rst, start, a, b, done and product[2*WIDTH-1:0].

Verification
REQ-034 WIDTH=32; ADD a=0xFFFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, result=0, overflow=1.
REQ-035 SUB a=3, b=5 -> result=0xFFFFFFFE, overflow=1; SUB a=5, b=3 -> result=2, overflow=0.
REQ-036 MULT a=0x10000, b=0x10000 -> out_valid rises 32 cycles after acceptance, result=0, overflow=1; MULT a=7, b=6 -> result=42, overflow=0.
REQ-037 XOR a=0xF0F0F0F0, b=0xFFFF0000 with out_ready=0 for 5 cycles -> result=0x0F0FF0F0 held stable, in_ready=0 throughout, then one output handshake.
REQ-038 rst asserted 10 cycles into a MULT -> next cycle out_valid=0, result=0, in_ready=1; no stale result is ever presented.
REQ-039 Undefined op=7 with a=1, b=1 -> result=0, overflow=0, latency 1.
